ascon_state_masker: RTL and testbench

- Share encoder feeding the 3-share threshold-implementation permutation datapath.
- Accepts an unshared 5x64-bit Ascon state and draws 10 fresh 64-bit random words from an RNG stream.
- Emits three Boolean shares per lane so that XOR of the shares equals the input lane.
- Holds the shared state until the permutation core accepts it.

---
 rtl/ascon_state_masker_if.sv | 31 +++
 rtl/ascon_state_masker.sv | 134 +++++++++++++
 tb/tb_ascon_state_masker.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_state_masker_if.sv
// Handshake and lane bundle around the Ascon share encoder.
// It groups the unshared input, the RNG stream and the three-share output.
interface ascon_state_masker_if #(parameter int LANE_W = 64);
  logic              in_valid;
  logic              in_ready;
  logic [LANE_W-1:0] x0, x1, x2, x3, x4;
  logic              rng_valid;
  logic              rng_ready;
  logic [LANE_W-1:0] rng_data;
  logic              out_valid;
  logic              out_ready;
  logic [LANE_W-1:0] x0_0, x1_0, x2_0, x3_0, x4_0;
  logic [LANE_W-1:0] x0_1, x1_1, x2_1, x3_1, x4_1;
  logic [LANE_W-1:0] x0_2, x1_2, x2_2, x3_2, x4_2;

  modport slave (
    input  in_valid, x0, x1, x2, x3, x4, rng_valid, rng_data, out_ready,
    output in_ready, rng_ready, out_valid,
    output x0_0, x1_0, x2_0, x3_0, x4_0,
    output x0_1, x1_1, x2_1, x3_1, x4_1,
    output x0_2, x1_2, x2_2, x3_2, x4_2
  );

  modport master (
    output in_valid, x0, x1, x2, x3, x4, rng_valid, rng_data, out_ready,
    input  in_ready, rng_ready, out_valid,
    input  x0_0, x1_0, x2_0, x3_0, x4_0,
    input  x0_1, x1_1, x2_1, x3_1, x4_1,
    input  x0_2, x1_2, x2_2, x3_2, x4_2
  );
endinterface

// File: rtl/ascon_state_masker.sv
// Three-share Boolean encoder for a 5x64 Ascon state.
// It consumes two random words per lane and holds the shares until they are taken.
module ascon_state_masker #(
  parameter int LANE_W    = 64,
  parameter int NUM_LANES = 5,
  parameter bit NOMASK    = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  ascon_state_masker_if.slave   bus
);
  localparam int NUM_WORDS = 2 * NUM_LANES;
  localparam int K_W       = $clog2(NUM_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [K_W-1:0]    r_k;
  logic [LANE_W-1:0] r_ra;
  logic [LANE_W-1:0] r_buf [NUM_LANES];
  logic [LANE_W-1:0] r_sh0 [NUM_LANES];
  logic [LANE_W-1:0] r_sh1 [NUM_LANES];
  logic [LANE_W-1:0] r_sh2 [NUM_LANES];
  logic              r_out_valid;
  logic              r_rng_ready;

  logic [LANE_W-1:0] w_x [NUM_LANES];
  logic [K_W-2:0]    w_lane;
  logic [LANE_W-1:0] w_rnd;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_capture;
  logic              w_last;

  assign w_x[0] = bus.x0;
  assign w_x[1] = bus.x1;
  assign w_x[2] = bus.x2;
  assign w_x[3] = bus.x3;
  assign w_x[4] = bus.x4;

  assign bus.x0_0 = r_sh0[0];
  assign bus.x1_0 = r_sh0[1];
  assign bus.x2_0 = r_sh0[2];
  assign bus.x3_0 = r_sh0[3];
  assign bus.x4_0 = r_sh0[4];
  assign bus.x0_1 = r_sh1[0];
  assign bus.x1_1 = r_sh1[1];
  assign bus.x2_1 = r_sh1[2];
  assign bus.x3_1 = r_sh1[3];
  assign bus.x4_1 = r_sh1[4];
  assign bus.x0_2 = r_sh2[0];
  assign bus.x1_2 = r_sh2[1];
  assign bus.x2_2 = r_sh2[2];
  assign bus.x3_2 = r_sh2[3];
  assign bus.x4_2 = r_sh2[4];

  // A new state can enter from IDLE, or from DONE in the cycle the result is taken.
  assign w_in_ready    = (r_state == IDLE) || ((r_state == DONE) && bus.out_ready);
  assign w_accept      = bus.in_valid && w_in_ready;
  assign w_capture     = (r_state == FETCH) && bus.rng_valid;
  assign w_last        = w_capture && (r_k == K_W'(NUM_WORDS - 1));
  assign w_lane        = r_k[K_W-1:1];
  assign w_rnd         = NOMASK ? {LANE_W{1'b0}} : bus.rng_data;
  assign bus.in_ready  = w_in_ready;
  assign bus.rng_ready = r_rng_ready;
  assign bus.out_valid = r_out_valid;

  // Next-state decode for the IDLE/FETCH/DONE sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = FETCH;
        else          w_state_nxt = IDLE;
      end
      FETCH: begin
        if (w_last) w_state_nxt = DONE;
        else        w_state_nxt = FETCH;
      end
      DONE: begin
        if (bus.out_ready) w_state_nxt = bus.in_valid ? FETCH : IDLE;
        else               w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register with the handshake flags registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_rng_ready <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt == DONE);
      r_rng_ready <= (w_state_nxt == FETCH);
    end
  end

  // Lane buffer, word counter and share registers; the odd word completes a lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k  <= '0;
      r_ra <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        r_buf[i] <= '0;
        r_sh0[i] <= '0;
        r_sh1[i] <= '0;
        r_sh2[i] <= '0;
      end
    end else if (w_accept) begin
      r_k <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        r_buf[i] <= w_x[i];
      end
    end else if (w_capture) begin
      r_k <= w_last ? '0 : r_k + K_W'(1);
      if (!r_k[0]) begin
        r_ra         <= w_rnd;
        r_sh1[w_lane] <= w_rnd;
      end else begin
        r_sh2[w_lane] <= w_rnd;
        r_sh0[w_lane] <= r_buf[w_lane] ^ r_ra ^ w_rnd;
        r_buf[w_lane] <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ascon_state_masker.sv
// Scoreboard bench for the share encoder, with a masked and a NOMASK instance in lockstep.
module tb_ascon_state_masker;
  typedef logic [4:0][63:0] lanes_t;
  typedef logic [9:0][63:0] words_t;
  typedef struct packed { lanes_t s0; lanes_t s1; lanes_t s2; } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  ascon_state_masker_if #(.LANE_W(64)) bus ();
  ascon_state_masker_if #(.LANE_W(64)) bus_nm ();

  assign bus_nm.in_valid  = bus.in_valid;
  assign bus_nm.x0        = bus.x0;
  assign bus_nm.x1        = bus.x1;
  assign bus_nm.x2        = bus.x2;
  assign bus_nm.x3        = bus.x3;
  assign bus_nm.x4        = bus.x4;
  assign bus_nm.rng_valid = bus.rng_valid;
  assign bus_nm.rng_data  = bus.rng_data;
  assign bus_nm.out_ready = bus.out_ready;

  ascon_state_masker #(.LANE_W(64), .NUM_LANES(5), .NOMASK(1'b0)) u_dut (
    .clk (clk), .rst (rst), .bus (bus.slave));
  ascon_state_masker #(.LANE_W(64), .NUM_LANES(5), .NOMASK(1'b1)) u_dut_nm (
    .clk (clk), .rst (rst), .bus (bus_nm.slave));

  function automatic exp_t model(input lanes_t x, input words_t w);
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      e.s1[i] = w[2*i];
      e.s2[i] = w[2*i+1];
      e.s0[i] = x[i] ^ w[2*i] ^ w[2*i+1];
    end
    return e;
  endfunction

  function automatic exp_t get_shares();
    exp_t r;
    r.s0 = {bus.x4_0, bus.x3_0, bus.x2_0, bus.x1_0, bus.x0_0};
    r.s1 = {bus.x4_1, bus.x3_1, bus.x2_1, bus.x1_1, bus.x0_1};
    r.s2 = {bus.x4_2, bus.x3_2, bus.x2_2, bus.x1_2, bus.x0_2};
    return r;
  endfunction

  function automatic exp_t get_shares_nm();
    exp_t r;
    r.s0 = {bus_nm.x4_0, bus_nm.x3_0, bus_nm.x2_0, bus_nm.x1_0, bus_nm.x0_0};
    r.s1 = {bus_nm.x4_1, bus_nm.x3_1, bus_nm.x2_1, bus_nm.x1_1, bus_nm.x0_1};
    r.s2 = {bus_nm.x4_2, bus_nm.x3_2, bus_nm.x2_2, bus_nm.x1_2, bus_nm.x0_2};
    return r;
  endfunction

  function automatic lanes_t rand_lanes();
    lanes_t x;
    for (int i = 0; i < 5; i++) x[i] = {$urandom, $urandom};
    return x;
  endfunction

  function automatic words_t rand_words();
    words_t w;
    for (int k = 0; k < 10; k++) w[k] = {$urandom, $urandom};
    return w;
  endfunction

  task automatic set_x(input lanes_t x);
    bus.x0 = x[0]; bus.x1 = x[1]; bus.x2 = x[2]; bus.x3 = x[3]; bus.x4 = x[4];
  endtask

  task automatic accept(input lanes_t x);
    bit ok = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    set_x(x);
    for (int c = 0; c < 50; c++) begin
      if (bus.in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL accept_timeout in_ready=0 required=1"); end
    @(posedge clk);
  endtask

  // Supplies words in order; a burst of 'stall' idle cycles starts at a random word index.
  task automatic feed(input words_t w, input int stall, output int cycles, output int hs_nm);
    int widx = 0;
    int left = stall;
    int at   = $urandom_range(1, 8);
    cycles = 0;
    hs_nm  = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      if (bus.out_valid) break;
      if (widx >= at && left > 0) begin
        bus.rng_valid = 1'b0;
        bus.rng_data  = {$urandom, $urandom};
        left--;
      end else begin
        bus.rng_valid = 1'b1;
        bus.rng_data  = w[(widx > 9) ? 9 : widx];
      end
      if (bus_nm.rng_ready && bus.rng_valid) hs_nm++;
      if (bus.rng_ready && bus.rng_valid) widx++;
      cycles++;
    end
    bus.rng_valid = 1'b0;
  endtask

  task automatic drain();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bit bad = 1'b0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.rng_valid = 1'b0; bus.rng_data = 64'h0; bus.out_ready = 1'b0;
    set_x(lanes_t'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, bus.in_ready, bus.rng_ready} !== 3'b010) begin
      n_fail++;
      $display("FAIL reset_flags got ov/ir/rr=%b required=010", {bus.out_valid, bus.in_ready, bus.rng_ready});
    end
    n_cmp++;
    if (get_shares() !== exp_t'(0)) begin
      n_fail++; $display("FAIL reset_shares got=%h required=0", get_shares());
    end
    for (int c = 0; c < 20; c++) begin
      bus.rng_valid = c[0];
      bus.rng_data  = {$urandom, $urandom};
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.rng_ready !== 1'b0) bad = 1'b1;
    end
    bus.rng_valid = 1'b0;
    n_cmp++;
    if (bad) begin n_fail++; $display("FAIL idle_rng_ignored got activity required out_valid=0 rng_ready=0"); end
  endtask

  task automatic test_basic(input int stall, input int lat_req);
    lanes_t x = {64'h5555555555555555, 64'h8000000000000001, 64'hFFFFFFFFFFFFFFFF,
                 64'h0, 64'h0123456789ABCDEF};
    words_t w;
    exp_t   e, got;
    int     lat, hs;
    bit     xbad = 1'b0;
    for (int k = 0; k < 10; k++) w[k] = 64'(k + 1);
    sb_q.push_back(model(x, w));
    accept(x);
    feed(w, stall, lat, hs);
    n_cmp++;
    if (lat !== lat_req) begin n_fail++; $display("FAIL basic_latency stall=%0d got=%0d required=%0d", stall, lat, lat_req); end
    got = get_shares();
    e   = sb_q.pop_front();
    n_cmp++;
    if (got !== e) begin n_fail++; $display("FAIL basic_shares stall=%0d got=%h required=%h", stall, got, e); end
    n_cmp++;
    if (got.s1[0] !== 64'd1 || got.s2[4] !== 64'd10 || got.s0[4] !== (64'h5555555555555555 ^ 64'd3)) begin
      n_fail++; $display("FAIL basic_fixed x0_1=%h x4_2=%h x4_0=%h required 1/a/5555555555555556", got.s1[0], got.s2[4], got.s0[4]);
    end
    for (int i = 0; i < 5; i++) if ((got.s0[i] ^ got.s1[i] ^ got.s2[i]) !== x[i]) xbad = 1'b1;
    n_cmp++;
    if (xbad) begin n_fail++; $display("FAIL basic_xor_recombine got mismatch required xor==x for all lanes"); end
    drain();
    n_cmp++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL basic_drain got ov/ir=%b required=01", {bus.out_valid, bus.in_ready});
    end
  endtask

  task automatic test_back_to_back();
    lanes_t xa = rand_lanes();
    lanes_t xb = rand_lanes();
    words_t wa = rand_words();
    words_t wb = rand_words();
    exp_t   e;
    int     lat, hs;
    bit     bad = 1'b0;
    sb_q.push_back(model(xa, wa));
    accept(xa);
    feed(wa, 0, lat, hs);
    e = sb_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || get_shares() !== e) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin n_fail++; $display("FAIL backpressure_hold got unstable or in_ready=1 required stable shares, in_ready=0"); end
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    set_x(xb);
    sb_q.push_back(model(xb, wb));
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready got=%b required=1", bus.in_ready); end
    @(posedge clk);
    feed(wb, 0, lat, hs);
    n_cmp++;
    if (lat !== 10) begin n_fail++; $display("FAIL b2b_latency got=%0d required=10", lat); end
    e = sb_q.pop_front();
    n_cmp++;
    if (get_shares() !== e) begin n_fail++; $display("FAIL b2b_shares got=%h required=%h", get_shares(), e); end
    drain();
  endtask

  task automatic test_mid_reset();
    lanes_t x  = rand_lanes();
    lanes_t x2 = rand_lanes();
    words_t w  = rand_words();
    words_t w2 = rand_words();
    exp_t   e;
    int     lat, hs;
    accept(x);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.rng_valid = 1'b1;
      bus.rng_data  = w[k];
    end
    @(negedge clk);
    bus.rng_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.rng_ready, bus.in_ready} !== 3'b001 || get_shares() !== exp_t'(0)) begin
      n_fail++;
      $display("FAIL mid_reset_clear got ov/rr/ir=%b shares=%h required=001 and 0", {bus.out_valid, bus.rng_ready, bus.in_ready}, get_shares());
    end
    @(negedge clk);
    rst = 1'b0;
    sb_q.push_back(model(x2, w2));
    accept(x2);
    feed(w2, 0, lat, hs);
    n_cmp++;
    if (lat !== 10) begin n_fail++; $display("FAIL post_reset_latency got=%0d required=10", lat); end
    e = sb_q.pop_front();
    n_cmp++;
    if (get_shares() !== e) begin n_fail++; $display("FAIL post_reset_shares got=%h required=%h", get_shares(), e); end
    drain();
  endtask

  task automatic test_nomask();
    lanes_t x = rand_lanes();
    words_t w = rand_words();
    exp_t   e;
    int     lat, hs;
    e.s0 = x;
    e.s1 = '0;
    e.s2 = '0;
    accept(x);
    feed(w, 0, lat, hs);
    n_cmp++;
    if (hs !== 10) begin n_fail++; $display("FAIL nomask_handshakes got=%0d required=10", hs); end
    n_cmp++;
    if (bus_nm.out_valid !== 1'b1) begin n_fail++; $display("FAIL nomask_out_valid got=%b required=1", bus_nm.out_valid); end
    n_cmp++;
    if (get_shares_nm() !== e) begin n_fail++; $display("FAIL nomask_shares got=%h required=%h", get_shares_nm(), e); end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic(0, 10);
    test_basic(7, 17);
    test_back_to_back();
    test_mid_reset();
    test_nomask();
    n_cmp++;
    if (sb_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got=%0d required=0", sb_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
